ula_result_bcd_decoder: RTL and testbench

Reads the 8-bit ULA result bus and the 3-bit operation select that produced it, then converts the result to three BCD digits for the 7-segment display path. The result is masked to the width that the selected operation actually produces before conversion. Conversion is iterative shift-add-3 (double dabble), one bit per clock, with a start/busy/done handshake. It sits between the ULA output selector and the board display drivers.

---
 rtl/ula_pkg.sv | 51 +++++
 rtl/bcd_to_7seg.sv | 27 ++
 rtl/ula_result_bcd_decoder.sv | 140 ++++++++++++++
 tb/tb_ula_result_bcd_decoder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA result display path: op codes, width classes,
// the BCD decoder FSM state type and the blank 7-segment pattern.
package ula_pkg;

  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  localparam logic [2:0] OP_5 = 3'd5;
  localparam logic [2:0] OP_6 = 3'd6;
  localparam logic [2:0] OP_7 = 3'd7;

  typedef enum logic [1:0] {
    WC_1B,
    WC_5B,
    WC_8B
  } width_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FINISH
  } state_t;

  localparam logic [6:0] BLANK_SEG = 7'h7F;

  // Width actually produced by each ULA operation.
  function automatic width_class_t op_width_class(input logic [2:0] op);
    width_class_t wc;
    wc = WC_8B;
    case (op)
      OP_0, OP_1, OP_6: wc = WC_5B;
      OP_2, OP_3, OP_5: wc = WC_1B;
      default:          wc = WC_8B;
    endcase
    return wc;
  endfunction

  function automatic logic [7:0] mask_result(input logic [2:0] op, input logic [7:0] r);
    logic [7:0] m;
    m = r;
    case (op_width_class(op))
      WC_1B:   m = {7'b0, r[0]};
      WC_5B:   m = {3'b0, r[4:0]};
      default: m = r;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder, bit order g..a.
// Only built when SEVEN_SEG_EN is defined, since nothing else instantiates it.
`ifdef SEVEN_SEG_EN
module bcd_to_7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  end

endmodule
`endif

// File: rtl/ula_result_bcd_decoder.sv
// Converts the masked ULA result to three BCD digits by double dabble, one bit per clock.
// Optional SEVEN_SEG_EN adds registered, leading-zero-blanked active-low segment outputs.
module ula_result_bcd_decoder
  import ula_pkg::*;
#(
  parameter int RES_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op_sel,
  input  logic [7:0] result,
  output logic       busy,
  output logic       done,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones
`ifdef SEVEN_SEG_EN
  ,
  output logic [6:0] seg_hund,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones
`endif
);

  // Handshake: start is sampled only in IDLE; busy is high from the cycle after
  // capture until the digits update; done pulses for one cycle alongside the new
  // digits, and start is accepted again in that same cycle. start while busy is dropped.

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(RES_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RES_W - 1);

  state_t             state_q, state_d;
  logic [RES_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d, done_d, load_digits;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    busy_d      = busy;
    done_d      = 1'b0;
    load_digits = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d    = mask_result(op_sel, result);
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj[BCD_W-2:0], sh_q, 1'b0};
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        load_digits = 1'b1;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_hund <= 4'd0;
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
    end else if (load_digits) begin
      bcd_hund <= bcd_q[8 +: 4];
      bcd_tens <= bcd_q[4 +: 4];
      bcd_ones <= bcd_q[0 +: 4];
    end
  end

`ifdef SEVEN_SEG_EN
  logic [6:0] raw_hund, raw_tens, raw_ones;

  bcd_to_7seg u_seg_hund (.digit(bcd_q[8 +: 4]), .seg(raw_hund));
  bcd_to_7seg u_seg_tens (.digit(bcd_q[4 +: 4]), .seg(raw_tens));
  bcd_to_7seg u_seg_ones (.digit(bcd_q[0 +: 4]), .seg(raw_ones));

  // Segments are decoded from the accumulator so they land on the same edge as the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_hund <= BLANK_SEG;
      seg_tens <= BLANK_SEG;
      seg_ones <= BLANK_SEG;
    end else if (load_digits) begin
      seg_hund <= (bcd_q[8 +: 4] == 4'd0) ? BLANK_SEG : raw_hund;
      seg_tens <= (bcd_q[8 +: 8] == 8'd0) ? BLANK_SEG : raw_tens;
      seg_ones <= raw_ones;
    end
  end
`endif

endmodule

// File: tb/tb_ula_result_bcd_decoder.sv
// Self-checking bench for ula_result_bcd_decoder: directed cases plus randomized
// back-to-back conversions checked against a decimal-arithmetic reference model.
module tb_ula_result_bcd_decoder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] op_sel;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
`ifdef SEVEN_SEG_EN
  logic [6:0] seg_hund, seg_tens, seg_ones;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  ula_result_bcd_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_sel   (op_sel),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .bcd_hund (bcd_hund),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones)
`ifdef SEVEN_SEG_EN
    ,
    .seg_hund (seg_hund),
    .seg_tens (seg_tens),
    .seg_ones (seg_ones)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int ref_value(input int op, input int res);
    if (op == 0 || op == 1 || op == 6) return res % 32;
    if (op == 2 || op == 3 || op == 5) return res % 2;
    return res % 256;
  endfunction

  function automatic logic [11:0] ref_digits(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

`ifdef SEVEN_SEG_EN
  function automatic logic [6:0] ref_seg(input int d);
    logic [6:0] tab [10];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tab[d];
  endfunction
`endif

  // ---------------- driver tasks ----------------
  // Pulse start for one cycle; returns at the falling edge of cycle 1.
  task automatic pulse_start(input logic [2:0] op, input logic [7:0] res);
    @(negedge clk);
    start  = 1'b1;
    op_sel = op;
    result = res;
    @(negedge clk);
    start  = 1'b0;
    op_sel = 3'($urandom);
    result = 8'($urandom);
  endtask

  // Wait for done; cyc is the cycle index relative to the start cycle.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_convert(input logic [2:0] op, input logic [7:0] res, output int cyc);
    pulse_start(op, res);
    wait_done(cyc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    op_sel = 3'd0;
    result = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, bcd_hund, bcd_tens, bcd_ones} !== 14'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b digits=%h%h%h, want all 0",
               busy, done, bcd_hund, bcd_tens, bcd_ones);
    end
`ifdef SEVEN_SEG_EN
    n_cmp++;
    if ({seg_hund, seg_tens, seg_ones} !== {3{7'h7F}}) begin
      n_err++;
      $display("FAIL reset_segs: got %h %h %h, want 7f 7f 7f", seg_hund, seg_tens, seg_ones);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    logic exp_busy, exp_done;
    logic [11:0] e;
    pulse_start(3'd4, 8'hFF);
    for (int c = 1; c <= 10; c++) begin
      exp_busy = (c <= 9);
      exp_done = (c == 10);
      n_cmp++;
      if (busy !== exp_busy || done !== exp_done) begin
        n_err++;
        $display("FAIL latency_cycle%0d: got busy=%b done=%b, want busy=%b done=%b",
                 c, busy, done, exp_busy, exp_done);
      end
      if (c < 10) @(negedge clk);
    end
    e = ref_digits(ref_value(4, 255));
    n_cmp++;
    if ({bcd_hund, bcd_tens, bcd_ones} !== e) begin
      n_err++;
      $display("FAIL latency_digits: got %h%h%h, want %h", bcd_hund, bcd_tens, bcd_ones, e);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || {bcd_hund, bcd_tens, bcd_ones} !== e) begin
      n_err++;
      $display("FAIL done_one_cycle_hold: got done=%b digits=%h%h%h, want done=0 digits=%h",
               done, bcd_hund, bcd_tens, bcd_ones, e);
    end
  endtask

  task automatic test_masking;
    logic [2:0] ops [4];
    logic [7:0] ress [4];
    logic [11:0] e;
    int cyc;
    ops  = '{3'd0, 3'd7, 3'd2, 3'd5};
    ress = '{8'hFF, 8'd100, 8'hFE, 8'h01};
    for (int i = 0; i < 4; i++) begin
      do_convert(ops[i], ress[i], cyc);
      e = ref_digits(ref_value(int'(ops[i]), int'(ress[i])));
      n_cmp++;
      if (cyc != 10 || {bcd_hund, bcd_tens, bcd_ones} !== e) begin
        n_err++;
        $display("FAIL mask_op%0d_res%0d: got %h%h%h at cycle %0d, want %h at cycle 10",
                 ops[i], ress[i], bcd_hund, bcd_tens, bcd_ones, cyc, e);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int n_done;
    logic [11:0] e;
    n_done = 0;
    pulse_start(3'd4, 8'd42);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    op_sel = 3'd4;
    result = 8'd99;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    e = ref_digits(42);
    n_cmp++;
    if (n_done != 1 || {bcd_hund, bcd_tens, bcd_ones} !== e) begin
      n_err++;
      $display("FAIL start_while_busy: got %0d done pulses digits=%h%h%h, want 1 pulse digits=%h",
               n_done, bcd_hund, bcd_tens, bcd_ones, e);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, n_done;
    do_convert(3'd4, 8'd200, cyc);
    n_cmp++;
    if ({bcd_hund, bcd_tens, bcd_ones} !== ref_digits(200)) begin
      n_err++;
      $display("FAIL pre_reset_200: got %h%h%h, want 200", bcd_hund, bcd_tens, bcd_ones);
    end
    pulse_start(3'd4, 8'd77);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, bcd_hund, bcd_tens, bcd_ones} !== 14'd0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b digits=%h%h%h, want all 0",
               busy, done, bcd_hund, bcd_tens, bcd_ones);
    end
    n_done = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    n_cmp++;
    if (n_done != 0 || {bcd_hund, bcd_tens, bcd_ones} !== 12'd0) begin
      n_err++;
      $display("FAIL aborted_conv: got %0d done pulses digits=%h%h%h, want 0 pulses digits=000",
               n_done, bcd_hund, bcd_tens, bcd_ones);
    end
    do_convert(3'd4, 8'd77, cyc);
    n_cmp++;
    if (cyc != 10 || {bcd_hund, bcd_tens, bcd_ones} !== ref_digits(77)) begin
      n_err++;
      $display("FAIL after_reset_77: got %h%h%h at cycle %0d, want 077 at cycle 10",
               bcd_hund, bcd_tens, bcd_ones, cyc);
    end
  endtask

  // Random conversions, each new start issued in the cycle done is high.
  task automatic test_back_to_back;
    int cyc, op, res;
    logic [11:0] e;
    @(negedge clk);
    op  = $urandom_range(7, 0);
    res = $urandom_range(255, 0);
    start  = 1'b1;
    op_sel = 3'(op);
    result = 8'(res);
    exp_q.push_back(ref_digits(ref_value(op, res)));
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      start  = 1'b0;
      op_sel = 3'($urandom);
      result = 8'($urandom);
      wait_done(cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (cyc != 10 || {bcd_hund, bcd_tens, bcd_ones} !== e) begin
        n_err++;
        $display("FAIL b2b_%0d: got %h%h%h at cycle %0d, want %h at cycle 10",
                 k, bcd_hund, bcd_tens, bcd_ones, cyc, e);
      end
      if (k < 23) begin
        op  = $urandom_range(7, 0);
        res = (k % 4 == 0) ? 255 : $urandom_range(255, 0);
        start  = 1'b1;
        op_sel = 3'(op);
        result = 8'(res);
        exp_q.push_back(ref_digits(ref_value(op, res)));
      end
    end
  endtask

`ifdef SEVEN_SEG_EN
  task automatic test_seven_seg;
    int cyc, v;
    logic [6:0] eh, et, eo;
    int vals [4];
    vals = '{7, 205, 48, 0};
    for (int i = 0; i < 4; i++) begin
      v = vals[i];
      do_convert(3'd4, 8'(v), cyc);
      eh = (v / 100 == 0) ? 7'h7F : ref_seg(v / 100);
      et = (v / 10 == 0) ? 7'h7F : ref_seg((v / 10) % 10);
      eo = ref_seg(v % 10);
      n_cmp++;
      if (seg_hund !== eh || seg_tens !== et || seg_ones !== eo) begin
        n_err++;
        $display("FAIL seg_%0d: got %h %h %h, want %h %h %h",
                 v, seg_hund, seg_tens, seg_ones, eh, et, eo);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_latency;
    test_masking;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
`ifdef SEVEN_SEG_EN
    test_seven_seg;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
